// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
//   Byte FIFO feeding an RS-232 transmitter. Producers may write up to one
//   byte per clock. A drain FSM issues one tx_start strobe per byte and waits
//   for the transmitter to raise and then drop tx_busy before it issues the
//   next strobe.
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   AW     pointer width, derived as log2(DEPTH)
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr_en     write strobe, one byte accepted per cycle when not full
//   wr_data   byte to enqueue
//   full      FIFO holds DEPTH entries
//   empty     FIFO holds 0 entries
//   level     current entry count, 0..DEPTH
//   overflow  sticky flag, a write arrived while full
//   ovf_clr   synchronous clear of overflow (an overflowing write wins)
//   tx_start  one-cycle start strobe to the transmitter
//   tx_data   byte presented with tx_start, held until the next start
//   tx_busy   transmitter busy flag
//
// Build option
//   UART_TXQ_CRLF_EN  when defined, each LF (8'h0A) is sent as CR LF. The CR
//                     is generated in the FSM and never occupies a FIFO entry.
// ---------------------------------------------------------------------------
module uart_tx_queue #(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          overflow,
   input  logic          ovf_clr,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   input  logic          tx_busy
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic          r_tx_start;
   logic [7:0]    r_tx_data;
   state_t        r_state;

   state_t        w_state_nxt;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_send;
   logic [7:0]    w_head;
   logic [7:0]    w_tx_byte;

`ifdef UART_TXQ_CRLF_EN
   logic          r_cr_done;
   logic          w_cr_ins;
`endif

   // Status flags come from the registered count only.
   assign w_full  = (r_count == LP_DEPTH);
   assign w_empty = (r_count == '0);
   assign w_head  = r_mem[r_rd_ptr];

   // full is the pre-edge value, so a write in the same cycle as a pop from a
   // full queue is still dropped.
   assign w_push  = wr_en && !w_full;

   // ------------------------------------------------------------------------
   // Drain FSM: next state and per-cycle send decision
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_send      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty && !tx_busy) begin
               w_send      = 1'b1;
               w_state_nxt = SEND;
            end
         end
         SEND:      w_state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (tx_busy)  w_state_nxt = WAIT_DONE;
         WAIT_DONE: if (!tx_busy) w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

`ifdef UART_TXQ_CRLF_EN
   // An LF at the head is sent twice through IDLE: first as CR without popping,
   // then as the LF itself with the pop.
   always_comb begin
      w_cr_ins  = w_send && (w_head == 8'h0A) && !r_cr_done;
      w_pop     = w_send && !w_cr_ins;
      w_tx_byte = w_cr_ins ? 8'h0D : w_head;
   end
`else
   always_comb begin
      w_pop     = w_send;
      w_tx_byte = w_head;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------------------
   // Storage (not reset)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

   // ------------------------------------------------------------------------
   // Pointers, count, overflow, transmitter interface
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase

         if (wr_en && w_full) r_overflow <= 1'b1;
         else if (ovf_clr)    r_overflow <= 1'b0;

         r_tx_start <= w_send;
         if (w_send) r_tx_data <= w_tx_byte;
      end
   end

`ifdef UART_TXQ_CRLF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_cr_done <= 1'b0;
      else if (w_send) r_cr_done <= w_cr_ins;
   end
`endif

   assign full     = w_full;
   assign empty    = w_empty;
   assign level    = r_count;
   assign overflow = r_overflow;
   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;

endmodule
